// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM command path.
//   SPEED_W      : width of the speed command shared with the PWM core
//   ramp_state_t : soft-start/soft-stop ramp FSM states
package pwm_pkg;

  localparam int unsigned SPEED_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    RAMP,
    HOLD,
    STOP
  } ramp_state_t;

endpackage

// File: rtl/speed_cmd_filter.sv
// Input conditioning for the speed ramp.
// Synchronizes the run switch and the target-speed switches, and debounces
// the target before handing it to the ramp FSM.
//   i_clock, i_reset : clock and synchronous active-high reset
//   i_run            : asynchronous run switch
//   i_target_speed   : asynchronous requested speed
//   o_run_s          : synchronized run (not debounced)
//   o_cmd_tgt        : debounced, accepted target speed
module speed_cmd_filter
  import pwm_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 1000
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_run,
  input  logic [SPEED_W-1:0] i_target_speed,
  output logic               o_run_s,
  output logic [SPEED_W-1:0] o_cmd_tgt
);

  localparam int unsigned CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic               r_run_m;
  logic               r_run_s;
  logic [SPEED_W-1:0] r_tgt_m;
  logic [SPEED_W-1:0] r_tgt_s;
  logic [CNT_W-1:0]   r_stab_cnt;
  logic [SPEED_W-1:0] r_cmd_tgt;
  logic               w_tgt_changing;

  // The first stage already holds the value tgt_s takes on this edge, so
  // comparing the stages detects a change on the edge it lands in tgt_s.
  assign w_tgt_changing = (r_tgt_m != r_tgt_s);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_run_m    <= 1'b0;
      r_run_s    <= 1'b0;
      r_tgt_m    <= '0;
      r_tgt_s    <= '0;
      r_stab_cnt <= '0;
      r_cmd_tgt  <= '0;
    end else begin
      r_run_m <= i_run;
      r_run_s <= r_run_m;
      r_tgt_m <= i_target_speed;
      r_tgt_s <= r_tgt_m;
      if (w_tgt_changing) begin
        r_stab_cnt <= '0;
      end else if (r_stab_cnt == CNT_LAST) begin
        // Counter saturates; the stable value is reloaded every cycle.
        r_cmd_tgt <= r_tgt_s;
      end else begin
        r_stab_cnt <= r_stab_cnt + 1'b1;
      end
    end
  end

  assign o_run_s   = r_run_s;
  assign o_cmd_tgt = r_cmd_tgt;

endmodule

// File: rtl/pwm_speed_ramp.sv
// Soft-start/soft-stop command stage feeding the PWM core.
// Slews speed one step per STEP_CYCLES toward the debounced target and
// ramps down to zero before dropping enable.
//   clock, reset    : clock and synchronous active-high reset
//   run             : asynchronous run request
//   target_speed    : asynchronous requested speed 0..7
//   pwm_enable      : registered enable to the PWM core
//   pwm_speed       : registered speed to the PWM core
//   at_target       : high in HOLD
//   busy            : high in RAMP or STOP
module pwm_speed_ramp
  import pwm_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 1000,
  parameter int unsigned STEP_CYCLES   = 100000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               run,
  input  logic [SPEED_W-1:0] target_speed,
  output logic               pwm_enable,
  output logic [SPEED_W-1:0] pwm_speed,
  output logic               at_target,
  output logic               busy
);

  localparam int unsigned STEP_W = $clog2(STEP_CYCLES);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYCLES - 1);

  ramp_state_t        r_state;
  logic [STEP_W-1:0]  r_step_cnt;
  logic [SPEED_W-1:0] r_speed;
  logic               r_enable;
  logic               r_at_target;
  logic               r_busy;

  logic               w_run_s;
  logic [SPEED_W-1:0] w_cmd_tgt;
  logic               w_tick;
  logic [SPEED_W-1:0] w_speed_toward;
  logic [SPEED_W-1:0] w_speed_down;

  speed_cmd_filter #(
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_filter (
    .i_clock        (clock),
    .i_reset        (reset),
    .i_run          (run),
    .i_target_speed (target_speed),
    .o_run_s        (w_run_s),
    .o_cmd_tgt      (w_cmd_tgt)
  );

  // Only selected when speed != cmd_tgt (RAMP) or speed != 0 (STOP),
  // so neither 0-1 nor 7+1 is ever used.
  assign w_tick         = (r_step_cnt == STEP_LAST);
  assign w_speed_down   = r_speed - 1'b1;
  assign w_speed_toward = (w_cmd_tgt > r_speed) ? r_speed + 1'b1 : w_speed_down;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_step_cnt  <= '0;
      r_speed     <= '0;
      r_enable    <= 1'b0;
      r_at_target <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_step_cnt <= '0;
          r_speed    <= '0;
          if (w_run_s) begin
            r_enable <= 1'b1;
            if (w_cmd_tgt == '0) begin
              r_state     <= HOLD;
              r_at_target <= 1'b1;
            end else begin
              r_state <= RAMP;
              r_busy  <= 1'b1;
            end
          end
        end
        RAMP: begin
          if (!w_run_s) begin
            r_state    <= STOP;
            r_step_cnt <= '0;
          end else if (r_speed == w_cmd_tgt) begin
            r_state     <= HOLD;
            r_step_cnt  <= '0;
            r_at_target <= 1'b1;
            r_busy      <= 1'b0;
          end else if (w_tick) begin
            r_speed    <= w_speed_toward;
            r_step_cnt <= '0;
            // Final step and the move to HOLD share one edge.
            if (w_speed_toward == w_cmd_tgt) begin
              r_state     <= HOLD;
              r_at_target <= 1'b1;
              r_busy      <= 1'b0;
            end
          end else begin
            r_step_cnt <= r_step_cnt + 1'b1;
          end
        end
        HOLD: begin
          r_step_cnt <= '0;
          if (!w_run_s) begin
            r_state     <= STOP;
            r_at_target <= 1'b0;
            r_busy      <= 1'b1;
          end else if (w_cmd_tgt != r_speed) begin
            r_state     <= RAMP;
            r_at_target <= 1'b0;
            r_busy      <= 1'b1;
          end
        end
        STOP: begin
          if (w_run_s) begin
            r_step_cnt <= '0;
            if (r_speed == w_cmd_tgt) begin
              r_state     <= HOLD;
              r_at_target <= 1'b1;
              r_busy      <= 1'b0;
            end else begin
              r_state <= RAMP;
            end
          end else if (r_speed == '0) begin
            r_state    <= IDLE;
            r_step_cnt <= '0;
            r_enable   <= 1'b0;
            r_busy     <= 1'b0;
          end else if (w_tick) begin
            r_speed    <= w_speed_down;
            r_step_cnt <= '0;
          end else begin
            r_step_cnt <= r_step_cnt + 1'b1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_step_cnt  <= '0;
          r_speed     <= '0;
          r_enable    <= 1'b0;
          r_at_target <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign pwm_enable = r_enable;
  assign pwm_speed  = r_speed;
  assign at_target  = r_at_target;
  assign busy       = r_busy;

endmodule

// File: tb/tb_pwm_speed_ramp.sv
module tb_pwm_speed_ramp;
  import pwm_pkg::*;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               run = 1'b0;
  logic [SPEED_W-1:0] target_speed = '0;
  logic               pwm_enable;
  logic [SPEED_W-1:0] pwm_speed;
  logic               at_target;
  logic               busy;

  int n_checks = 0;
  int n_fail   = 0;

  pwm_speed_ramp #(
    .STABLE_CYCLES (4),
    .STEP_CYCLES   (8)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .run          (run),
    .target_speed (target_speed),
    .pwm_enable   (pwm_enable),
    .pwm_speed    (pwm_speed),
    .at_target    (at_target),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  // Advance n rising edges, then sample 1 time unit later.
  task automatic clk(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; run = 1'b0; target_speed = '0;
    clk(3);
    reset = 1'b0;
    clk(1);
    n_checks++;
    if ({pwm_enable, pwm_speed, at_target, busy} !== 6'b0) begin
      n_fail++; $display("FAIL reset_outputs: got %b expected 000000", {pwm_enable, pwm_speed, at_target, busy});
    end
    n_checks++;
    if (dut.w_cmd_tgt !== 3'd0) begin
      n_fail++; $display("FAIL reset_cmd_tgt: got %0d expected 0", dut.w_cmd_tgt);
    end
  endtask

  task automatic test_ramp_up();
    target_speed = 3'd3;
    clk(5);
    n_checks++;
    if (dut.w_cmd_tgt !== 3'd0) begin
      n_fail++; $display("FAIL accept_early: got %0d expected 0", dut.w_cmd_tgt);
    end
    clk(1);
    n_checks++;
    if (dut.w_cmd_tgt !== 3'd3) begin
      n_fail++; $display("FAIL accept_time: got %0d expected 3", dut.w_cmd_tgt);
    end
    run = 1'b1;
    clk(2);
    n_checks++;
    if (pwm_enable !== 1'b0) begin
      n_fail++; $display("FAIL enable_early: got %b expected 0", pwm_enable);
    end
    clk(1);
    n_checks++;
    if ({pwm_enable, pwm_speed, at_target, busy} !== 6'b1_000_0_1) begin
      n_fail++; $display("FAIL enter_ramp: got %b expected 100001", {pwm_enable, pwm_speed, at_target, busy});
    end
    for (int s = 1; s <= 3; s++) begin
      clk(7);
      n_checks++;
      if (pwm_speed !== 3'(s - 1)) begin
        n_fail++; $display("FAIL ramp_hold_%0d: got %0d expected %0d", s, pwm_speed, s - 1);
      end
      clk(1);
      n_checks++;
      if (pwm_speed !== 3'(s)) begin
        n_fail++; $display("FAIL ramp_step_%0d: got %0d expected %0d", s, pwm_speed, s);
      end
    end
    n_checks++;
    if ({at_target, busy} !== 2'b10) begin
      n_fail++; $display("FAIL ramp_done_flags: got %b expected 10", {at_target, busy});
    end
  endtask

  task automatic test_glitch();
    target_speed = 3'd6;
    clk(2);
    target_speed = 3'd3;
    for (int i = 0; i < 12; i++) begin
      clk(1);
      n_checks++;
      if ({pwm_speed, at_target} !== {3'd3, 1'b1}) begin
        n_fail++; $display("FAIL glitch_hold_%0d: got speed %0d at %b expected speed 3 at 1", i, pwm_speed, at_target);
      end
    end
    n_checks++;
    if (dut.w_cmd_tgt !== 3'd3) begin
      n_fail++; $display("FAIL glitch_cmd: got %0d expected 3", dut.w_cmd_tgt);
    end
  endtask

  task automatic test_reverse();
    int n;
    target_speed = 3'd7;
    n = 0;
    while (pwm_speed !== 3'd4 && n < 100) begin
      clk(1);
      n++;
    end
    n_checks++;
    if (pwm_speed !== 3'd4) begin
      n_fail++; $display("FAIL reverse_reach4: got %0d expected 4", pwm_speed);
    end
    // cmd_tgt 7 accepted at edge 6, RAMP at 7, steps at 15 (4).
    n_checks++;
    if (n !== 15) begin
      n_fail++; $display("FAIL reverse_reach4_time: got %0d expected 15", n);
    end
    target_speed = 3'd2;
    clk(7);
    n_checks++;
    if (pwm_speed !== 3'd4) begin
      n_fail++; $display("FAIL reverse_wait: got %0d expected 4", pwm_speed);
    end
    clk(1);
    n_checks++;
    if ({pwm_speed, at_target} !== {3'd3, 1'b0}) begin
      n_fail++; $display("FAIL reverse_step3: got speed %0d at %b expected speed 3 at 0", pwm_speed, at_target);
    end
    clk(8);
    n_checks++;
    if ({pwm_speed, at_target, busy} !== {3'd2, 2'b10}) begin
      n_fail++; $display("FAIL reverse_hold2: got %b expected 01010", {pwm_speed, at_target, busy});
    end
  endtask

  task automatic test_stop();
    run = 1'b0;
    clk(2);
    n_checks++;
    if ({at_target, busy} !== 2'b10) begin
      n_fail++; $display("FAIL stop_early: got %b expected 10", {at_target, busy});
    end
    clk(1);
    n_checks++;
    if ({pwm_enable, pwm_speed, at_target, busy} !== 6'b1_010_0_1) begin
      n_fail++; $display("FAIL stop_enter: got %b expected 101001", {pwm_enable, pwm_speed, at_target, busy});
    end
    clk(7);
    n_checks++;
    if (pwm_speed !== 3'd2) begin
      n_fail++; $display("FAIL stop_wait: got %0d expected 2", pwm_speed);
    end
    clk(1);
    n_checks++;
    if (pwm_speed !== 3'd1) begin
      n_fail++; $display("FAIL stop_step1: got %0d expected 1", pwm_speed);
    end
    clk(8);
    n_checks++;
    if ({pwm_enable, pwm_speed} !== 4'b1_000) begin
      n_fail++; $display("FAIL stop_step0: got %b expected 1000", {pwm_enable, pwm_speed});
    end
    clk(1);
    n_checks++;
    if ({pwm_enable, busy} !== 2'b00) begin
      n_fail++; $display("FAIL stop_idle: got %b expected 00", {pwm_enable, busy});
    end
  endtask

  task automatic test_stop_rerun();
    run = 1'b1;
    clk(3);
    n_checks++;
    if ({pwm_enable, pwm_speed, busy} !== 5'b1_000_1) begin
      n_fail++; $display("FAIL rerun_ramp: got %b expected 10001", {pwm_enable, pwm_speed, busy});
    end
    clk(16);
    n_checks++;
    if ({pwm_speed, at_target} !== {3'd2, 1'b1}) begin
      n_fail++; $display("FAIL rerun_hold2: got speed %0d at %b expected speed 2 at 1", pwm_speed, at_target);
    end
    run = 1'b0;
    clk(11);
    n_checks++;
    if ({pwm_speed, busy} !== {3'd1, 1'b1}) begin
      n_fail++; $display("FAIL rerun_stop1: got speed %0d busy %b expected speed 1 busy 1", pwm_speed, busy);
    end
    run = 1'b1;
    clk(3);
    n_checks++;
    if ({pwm_enable, pwm_speed, at_target, busy} !== 6'b1_001_0_1) begin
      n_fail++; $display("FAIL rerun_back_ramp: got %b expected 100101", {pwm_enable, pwm_speed, at_target, busy});
    end
    clk(8);
    n_checks++;
    if ({pwm_speed, at_target, busy} !== {3'd2, 2'b10}) begin
      n_fail++; $display("FAIL rerun_back_hold: got %b expected 01010", {pwm_speed, at_target, busy});
    end
  endtask

  task automatic test_zero_target();
    target_speed = 3'd0;
    run = 1'b0;
    clk(20);
    n_checks++;
    if ({pwm_enable, pwm_speed, busy} !== 5'b0) begin
      n_fail++; $display("FAIL zero_idle: got %b expected 00000", {pwm_enable, pwm_speed, busy});
    end
    run = 1'b1;
    clk(3);
    n_checks++;
    if ({pwm_enable, pwm_speed, at_target, busy} !== 6'b1_000_1_0) begin
      n_fail++; $display("FAIL zero_hold: got %b expected 100010", {pwm_enable, pwm_speed, at_target, busy});
    end
  endtask

  task automatic test_reset_mid_hold();
    run = 1'b0;
    clk(6);
    n_checks++;
    if (pwm_enable !== 1'b0) begin
      n_fail++; $display("FAIL rmh_idle: got %b expected 0", pwm_enable);
    end
    target_speed = 3'd5;
    clk(6);
    run = 1'b1;
    clk(3 + 40);
    n_checks++;
    if ({pwm_speed, at_target} !== {3'd5, 1'b1}) begin
      n_fail++; $display("FAIL rmh_hold5: got speed %0d at %b expected speed 5 at 1", pwm_speed, at_target);
    end
    reset = 1'b1;
    clk(1);
    n_checks++;
    if ({pwm_enable, pwm_speed, at_target, busy} !== 6'b0) begin
      n_fail++; $display("FAIL rmh_outputs: got %b expected 000000", {pwm_enable, pwm_speed, at_target, busy});
    end
    n_checks++;
    if (dut.r_state !== IDLE) begin
      n_fail++; $display("FAIL rmh_state: got %0d expected %0d", dut.r_state, IDLE);
    end
    reset = 1'b0;
    run = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_glitch();
    test_reverse();
    test_stop();
    test_stop_rerun();
    test_zero_target();
    test_reset_mid_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_speed_ramp.md
# pwm_speed_ramp

Soft-start/soft-stop command stage directly upstream of `PWM_module`. It synchronizes the raw run switch and 3-bit target-speed switches, debounces the target, and slews the `speed` and `enable` fed to the PWM core by one step per programmable interval. The motor or LED load therefore never sees an abrupt duty change. The top level wires `pwm_enable`/`pwm_speed` straight to the PWM core's `enable`/`speed`.

## Interface
- `STABLE_CYCLES`, default 1000: consecutive identical synchronized samples required before a new target is accepted; minimum 1.
- `STEP_CYCLES`, default 100000: clock cycles between ramp steps; minimum 2.
- `clock`, in, 1: the single clock; all logic is on the rising edge.
- `reset`, in, 1: synchronous, active-high.
- `run`, in, 1: asynchronous run request from a switch.
- `target_speed`, in, 3: asynchronous requested speed, 0..7.
- `pwm_enable`, out, 1: registered; drives the PWM core `enable`.
- `pwm_speed`, out, 3: registered; drives the PWM core `speed`.
- `at_target`, out, 1: registered; high in HOLD.
- `busy`, out, 1: registered; high in RAMP or STOP.

## Operation
- Sync: `run` and `target_speed` each pass through a 2-flop synchronizer, giving `run_s` and `tgt_s`.
- Filter:
  - `stab_cnt` clears whenever `tgt_s` differs from its previous sample.
  - When `tgt_s` has been equal for `STABLE_CYCLES` consecutive cycles, `cmd_tgt <= tgt_s`.
  - `run_s` is not filtered.
- Step timer:
  - Cleared and held at 0 in IDLE and HOLD, and on every state transition.
  - In RAMP and STOP it counts 0..`STEP_CYCLES`-1. The cycle at the terminal count is a `tick`, after which it wraps to 0.
- States:
  - IDLE: enable=0, speed=0. `run_s`=1 → HOLD if `cmd_tgt`==0, else RAMP.
  - RAMP:
    - On `tick`, speed moves ±1 toward `cmd_tgt`, with direction re-evaluated at each tick using the live `cmd_tgt`.
    - speed==`cmd_tgt` → HOLD.
    - `run_s`=0 → STOP; this takes priority over the tick in the same cycle.
  - HOLD: `cmd_tgt`≠speed → RAMP. `run_s`=0 → STOP, which takes priority.
  - STOP:
    - On `tick`, speed decrements.
    - speed==0 → IDLE.
    - `run_s`=1 → RAMP, or HOLD if speed==`cmd_tgt`.
- `pwm_enable`=1 in RAMP, HOLD and STOP.
- Arithmetic: speed is 3-bit unsigned. Steps never overshoot the target, and no wrap-around is possible (0-1 and 7+1 are never computed).

## Timing
- Reset values: all outputs 0, state IDLE, `cmd_tgt`=0, both counters 0, synchronizer flops 0.
- All outputs are registered and reflect the state entered on the same edge.
- `run` rises → `pwm_enable` is high 3 edges later (2 sync + 1 state).
- Target acceptance: `cmd_tgt` updates `STABLE_CYCLES`+2 edges after a clean input change. Any glitch restarts the window.
- Ramp: the first step occurs `STEP_CYCLES` cycles after entering RAMP or STOP, and subsequent steps follow every `STEP_CYCLES` cycles.
- Full 0→7 ramp takes 7×`STEP_CYCLES` cycles. `at_target` rises on the same edge as the final step.
- STOP at speed 0 → IDLE on the next edge, and `pwm_enable` falls there.
- Reset mid-ramp: next edge returns all outputs to 0 immediately. The ramp-down is skipped.

## Structure
- Package `pwm_pkg`:
  - `SPEED_W`=3.
  - `ramp_state_t` enum {IDLE, RAMP, HOLD, STOP}.
  - Shared with the PWM core for the speed width.
- Sub-module `speed_cmd_filter`: both synchronizers plus the stability counter. Outputs `run_s` and `cmd_tgt`.
- Ramp FSM, step timer and output registers stay in `pwm_speed_ramp`.
- Counter widths are `$clog2` of their parameter.

## Test plan
All scenarios use `STABLE_CYCLES`=4 and `STEP_CYCLES`=8.
1. Reset asserted mid-HOLD at speed 5 → next edge: enable=0, speed=0, at_target=0, busy=0, state IDLE.
2. target=3 held, then run=1 → enable high 3 edges after run; speed steps 0→1→2→3 at 8-cycle intervals; at_target rises with the 3rd step; busy falls with it.
3. In HOLD at 3, target glitches to 6 for 2 cycles and back to 3 → `cmd_tgt` stays 3, speed unchanged, at_target stays 1.
4. Ramping 0→7 and at speed 4, target changes to 2 → after acceptance, speed reverses: 4→3→2, then HOLD. No value above 5 is ever observed.
5. HOLD at 2, run=0 → STOP; speed 2→1→0 at 8-cycle steps; enable falls 1 edge after speed reaches 0. In a repeat, run=1 re-asserted at speed 1 returns the block to RAMP toward `cmd_tgt`.
6. run=1 with target=0 → HOLD immediately; enable=1, speed=0, at_target=1, busy=0.
